tx_psdu_framer: RTL

TX_PSDU_FRAMER -- requirements
Module: tx_psdu_framer

---
 rtl/tx_psdu_framer_pkg.sv | 25 ++
 rtl/crc32_byte_update.sv | 28 ++
 rtl/tx_psdu_framer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/tx_psdu_framer_pkg.sv
//------------------------------------------------------------------------------
// Module   : tx_psdu_framer_pkg
// Brief    : Shared state encoding and CRC-32 constants for the PSDU framer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package tx_psdu_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_FCS  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic [31:0] C_CRC_POLY  = 32'hEDB8_8320;
    localparam logic [31:0] C_CRC_INIT  = 32'hFFFF_FFFF;
    localparam int          C_MIN_LEN   = 5;
    localparam int          C_FCS_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/crc32_byte_update.sv
//------------------------------------------------------------------------------
// Module   : crc32_byte_update
// Brief    : Combinational reflected CRC-32 advance by one byte, LSB first.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module crc32_byte_update
    import tx_psdu_framer_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] w_crc;

    always_comb begin
        w_crc = i_crc ^ {24'h0, i_data};
        for (int i = 0; i < 8; i++) begin
            w_crc = w_crc[0] ? ((w_crc >> 1) ^ C_CRC_POLY) : (w_crc >> 1);
        end
        o_crc = w_crc;
    end

endmodule

`default_nettype wire

// File: rtl/tx_psdu_framer.sv
//------------------------------------------------------------------------------
// Module   : tx_psdu_framer
// Brief    : Frames a payload stream into a PSDU with header strobe and CRC-32 FCS.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tx_psdu_framer
    import tx_psdu_framer_pkg::*;
#(
    parameter int LEN_WIDTH       = 16,
    parameter int MAX_LEN         = 4095,
    parameter int UNDERRUN_CYCLES = 255
)(
    input  logic                 s00_axi_aclk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 start,
    input  logic [7:0]           tx_rate,
    input  logic [LEN_WIDTH-1:0] tx_len,
    input  logic [7:0]           payload_byte,
    input  logic                 payload_valid,
    output logic                 payload_ready,
    input  logic                 byte_out_ready,
    output logic                 hdr_strobe,
    output logic [7:0]           hdr_rate,
    output logic [LEN_WIDTH-1:0] hdr_len,
    output logic [7:0]           byte_out,
    output logic                 byte_out_strobe,
    output logic [LEN_WIDTH-1:0] byte_count,
    output logic                 fcs_out_strobe,
    output logic                 busy,
    output logic                 error,
    output logic [2:0]           state,
    output logic                 state_changed
);

    localparam int C_UR_W = $clog2(UNDERRUN_CYCLES + 1);

    state_e               r_state;
    state_e               w_state_next;
    logic                 r_state_changed;
    logic                 r_error;
    logic [7:0]           r_hdr_rate;
    logic [LEN_WIDTH-1:0] r_hdr_len;
    logic [7:0]           r_byte_out;
    logic                 r_byte_out_strobe;
    logic                 r_fcs_out_strobe;
    logic [LEN_WIDTH-1:0] r_byte_count;
    logic [31:0]          r_crc;
    logic [1:0]           r_fcs_idx;
    logic [C_UR_W-1:0]    r_underrun_cnt;

    logic                 w_len_ok;
    logic                 w_accept;
    logic                 w_reject;
    logic                 w_abort;
    logic                 w_xfer;
    logic                 w_last_payload;
    logic                 w_idle_cycle;
    logic                 w_underrun_hit;
    logic                 w_fcs_emit;
    logic [31:0]          w_crc_next;
    logic [31:0]          w_fcs_word;
    logic [7:0]           w_fcs_byte;

    crc32_byte_update u_crc (
        .i_crc  (r_crc),
        .i_data (payload_byte),
        .o_crc  (w_crc_next)
    );

    assign w_len_ok = (tx_len >= LEN_WIDTH'(C_MIN_LEN)) && (tx_len <= LEN_WIDTH'(MAX_LEN));

    assign payload_ready  = (r_state == ST_DATA) && byte_out_ready && enable;
    assign w_xfer         = payload_valid && payload_ready;
    assign w_last_payload = (r_byte_count + LEN_WIDTH'(1)) == (r_hdr_len - LEN_WIDTH'(C_FCS_BYTES));
    assign w_idle_cycle   = (r_state == ST_DATA) && enable && byte_out_ready && !payload_valid;
    assign w_underrun_hit = w_idle_cycle && (r_underrun_cnt == C_UR_W'(UNDERRUN_CYCLES - 1));
    assign w_fcs_emit     = (r_state == ST_FCS) && enable && byte_out_ready;

    // FCS goes out as the complemented CRC, least significant byte first.
    assign w_fcs_word = ~r_crc;
    assign w_fcs_byte = w_fcs_word[{r_fcs_idx, 3'b000} +: 8];

    always_ff @(posedge s00_axi_aclk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && enable) begin
                    if (w_len_ok) begin
                        w_accept     = 1'b1;
                        w_state_next = ST_HDR;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            ST_HDR: begin
                if (!enable) w_abort = 1'b1;
                else         w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (!enable || w_underrun_hit)   w_abort = 1'b1;
                else if (w_xfer && w_last_payload) w_state_next = ST_FCS;
            end
            ST_FCS: begin
                if (!enable)                                  w_abort = 1'b1;
                else if (byte_out_ready && r_fcs_idx == 2'd3) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                if (!enable) w_abort = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (w_abort) w_state_next = ST_IDLE;
    end

    always_ff @(posedge s00_axi_aclk or posedge reset) begin
        if (reset) begin
            r_state_changed   <= 1'b0;
            r_error           <= 1'b0;
            r_hdr_rate        <= '0;
            r_hdr_len         <= '0;
            r_byte_out        <= '0;
            r_byte_out_strobe <= 1'b0;
            r_fcs_out_strobe  <= 1'b0;
            r_byte_count      <= '0;
            r_crc             <= C_CRC_INIT;
            r_fcs_idx         <= '0;
            r_underrun_cnt    <= '0;
        end else begin
            r_state_changed   <= (w_state_next != r_state);
            r_error           <= w_abort | w_reject;
            r_byte_out_strobe <= 1'b0;
            r_fcs_out_strobe  <= 1'b0;

            if (w_accept) begin
                r_hdr_rate     <= tx_rate;
                r_hdr_len      <= tx_len;
                r_byte_count   <= '0;
                r_crc          <= C_CRC_INIT;
                r_fcs_idx      <= '0;
                r_underrun_cnt <= '0;
            end

            if (w_xfer) begin
                r_byte_out        <= payload_byte;
                r_byte_out_strobe <= 1'b1;
                r_byte_count      <= r_byte_count + LEN_WIDTH'(1);
                r_crc             <= w_crc_next;
                r_underrun_cnt    <= '0;
            end else if (w_idle_cycle) begin
                r_underrun_cnt <= r_underrun_cnt + C_UR_W'(1);
            end

            if (w_fcs_emit) begin
                r_byte_out        <= w_fcs_byte;
                r_byte_out_strobe <= 1'b1;
                r_fcs_out_strobe  <= (r_fcs_idx == 2'd3);
                r_byte_count      <= r_byte_count + LEN_WIDTH'(1);
                r_fcs_idx         <= r_fcs_idx + 2'd1;
            end
        end
    end

    assign hdr_strobe      = (r_state == ST_HDR);
    assign hdr_rate        = r_hdr_rate;
    assign hdr_len         = r_hdr_len;
    assign byte_out        = r_byte_out;
    assign byte_out_strobe = r_byte_out_strobe;
    assign byte_count      = r_byte_count;
    assign fcs_out_strobe  = r_fcs_out_strobe;
    assign busy            = (r_state != ST_IDLE);
    assign error           = r_error;
    assign state           = r_state;
    assign state_changed   = r_state_changed;

endmodule

`default_nettype wire
